// File: rtl/sound_store_rx.sv
// UART-to-RAM capture into a ping-pong buffer; each frame strobe swaps the readable bank.
// Define SOUND_STORE_PARITY_EN to receive 8E1 with even-parity checking (default 8N1).
`timescale 1ns/1ps

module sound_store_rx #(
  parameter int BIT_LEN        = 48,
  parameter int BYTES_PER_WORD = 2,
  parameter int ADDR_W         = 9
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        frame,
  input  logic                        rx,
  input  logic [ADDR_W-1:0]           rd_addr,
  output logic [8*BYTES_PER_WORD-1:0] q,
  output logic                        bank_rd,
  output logic [13:0]                 bytes_written,
  output logic [13:0]                 bytes_last,
  output logic                        frame_err,
  output logic                        parity_err,
  output logic                        overflow
);

  localparam int W      = 8 * BYTES_PER_WORD;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int MID    = BIT_LEN / 2;
  localparam int CNT_W  = $clog2(BIT_LEN);
  localparam int LANE_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

  localparam logic [CNT_W-1:0]  MID_LAST  = CNT_W'(MID - 1);
  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(BIT_LEN - 1);
  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(BYTES_PER_WORD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef SOUND_STORE_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_ACCEPT,
    S_WRITE,
    S_BREAK
  } state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic               rx_meta, rx_sync;
  logic [7:0]         shift;
  logic [2:0]         bit_idx;
  logic [W-1:0]       word_reg;
  logic [LANE_W-1:0]  lane;
  logic [ADDR_W-1:0]  wr_addr;
  logic               full;
  logic               bank_wr;
  logic               shift_en, stop_bad, accept, wr_en;
  logic [13:0]        bw_inc, bw_next;
  logic [W-1:0]       mem [0:2*DEPTH-1];

`ifdef SOUND_STORE_PARITY_EN
  logic par_bit, par_en, par_fail, par_bad;
  assign par_bad = ^{shift, par_bit};
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // All bit-period sampling hangs off the single counter; cnt restarts at every sample point.
  always_comb begin
    state_next = state;
    cnt_next   = cnt + CNT_W'(1);
    shift_en   = 1'b0;
    stop_bad   = 1'b0;
    accept     = 1'b0;
    wr_en      = 1'b0;
`ifdef SOUND_STORE_PARITY_EN
    par_en     = 1'b0;
    par_fail   = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        cnt_next = '0;
        if (!rx_sync) state_next = S_START;
      end
      S_START: begin
        if (cnt == MID_LAST) begin
          cnt_next   = '0;
          state_next = rx_sync ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_next = '0;
          shift_en = 1'b1;
`ifdef SOUND_STORE_PARITY_EN
          if (bit_idx == 3'd7) state_next = S_PARITY;
`else
          if (bit_idx == 3'd7) state_next = S_STOP;
`endif
        end
      end
`ifdef SOUND_STORE_PARITY_EN
      S_PARITY: begin
        if (cnt == BIT_LAST) begin
          cnt_next   = '0;
          par_en     = 1'b1;
          state_next = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_next = '0;
          if (!rx_sync) begin
            stop_bad   = 1'b1;
            state_next = S_BREAK;
`ifdef SOUND_STORE_PARITY_EN
          end else if (par_bad) begin
            par_fail   = 1'b1;
            state_next = S_IDLE;
`endif
          end else begin
            state_next = S_ACCEPT;
          end
        end
      end
      S_ACCEPT: begin
        cnt_next   = '0;
        accept     = 1'b1;
        state_next = (lane == LANE_LAST) ? S_WRITE : S_IDLE;
      end
      S_WRITE: begin
        cnt_next   = '0;
        wr_en      = 1'b1;
        state_next = S_IDLE;
      end
      S_BREAK: begin
        cnt_next = '0;
        if (rx_sync) state_next = S_IDLE;
      end
      default: begin
        cnt_next   = '0;
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shift    <= '0;
      bit_idx  <= '0;
      word_reg <= '0;
      lane     <= '0;
    end else begin
      if (state == S_START) bit_idx <= '0;
      if (shift_en) begin
        shift   <= {rx_sync, shift[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
      if (accept) word_reg[{lane, 3'b000} +: 8] <= shift;
      // A frame without a same-cycle WRITE throws the partial word away.
      if (frame || wr_en) lane <= '0;
      else if (accept && lane != LANE_LAST) lane <= lane + LANE_W'(1);
    end
  end

  assign bw_inc  = (bytes_written == 14'h3FFF) ? bytes_written : bytes_written + 14'd1;
  assign bw_next = accept ? bw_inc : bytes_written;

  // Frame is applied after same-cycle accept/WRITE, so that activity lands in the outgoing frame.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_addr       <= '0;
      full          <= 1'b0;
      bank_wr       <= 1'b0;
      bank_rd       <= 1'b1;
      bytes_written <= '0;
      bytes_last    <= '0;
      frame_err     <= 1'b0;
      overflow      <= 1'b0;
    end else if (frame) begin
      wr_addr       <= '0;
      full          <= 1'b0;
      bank_rd       <= bank_wr;
      bank_wr       <= ~bank_wr;
      bytes_last    <= bw_next;
      bytes_written <= '0;
      frame_err     <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      bytes_written <= bw_next;
      if (stop_bad) frame_err <= 1'b1;
      if (wr_en) begin
        if (full) overflow <= 1'b1;
        else if (wr_addr == ADDR_W'(DEPTH - 1)) full <= 1'b1;
        else wr_addr <= wr_addr + ADDR_W'(1);
      end
    end
  end

`ifdef SOUND_STORE_PARITY_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (par_en) par_bit <= rx_sync;
      if (frame) parity_err <= 1'b0;
      else if (par_fail) parity_err <= 1'b1;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (wr_en && !full) mem[{bank_wr, wr_addr}] <= word_reg;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) q <= '0;
    else          q <= mem[{bank_rd, rd_addr}];
  end

endmodule
